// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
//   Shared types and default widths for the IF/MEM memory port arbiter.
//   arb_state_t  : transaction FSM state (IDLE -> ISSUE -> WAIT -> RESP)
//   arb_owner_t  : which pipeline port owns the current memory transaction
package mem_port_arbiter_pkg;

  localparam int ISIZE = 32;
  localparam int DSIZE = 32;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } arb_owner_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the fetch port, the data port, the stall outputs and the
//   single-ported memory handshake used by mem_port_arbiter.
//   slave  : arbiter view (requests/memory responses in, valids/stalls/memory request out)
//   master : environment view (pipeline stages plus memory), the mirror of slave
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_valid;
  logic [DATA_W-1:0] if_rdata;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_valid;
  logic [DATA_W-1:0] dm_rdata;

  logic              stall_if;
  logic              stall_mem;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr,
    output if_valid, if_rdata,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    output dm_valid, dm_rdata,
    output stall_if, stall_mem,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_valid, if_rdata,
    output dm_req, dm_we, dm_addr, dm_wdata,
    input  dm_valid, dm_rdata,
    input  stall_if, stall_mem,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );

endinterface

// File: rtl/mem_port_arbiter_starve_counter.sv
// arb_starve_counter
//   Counts consecutive arbitrations the fetch port lost to the data port.
//   clk, rst : clock and synchronous active-high reset
//   inc      : data port granted while fetch was requesting
//   clr      : fetch granted or fetch not requesting (wins over inc)
//   at_max   : count has saturated at MAX, fetch must win next arbitration
module arb_starve_counter #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam int W = (MAX < 1) ? 1 : $clog2(MAX + 1);

  logic [W-1:0] cnt;

  assign at_max = (cnt == W'(MAX));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && !at_max) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported memory between the IF stage (fetch) and the MEM
//   stage (load/store). One outstanding transaction at a time; the data port
//   wins ties unless fetch has lost STARVE_MAX arbitrations in a row.
//   clk, rst : clock and synchronous active-high reset
//   bus      : fetch port, data port, stall outputs and memory handshake
//              (see mem_port_arbiter_if, slave modport)
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  arb_state_t state;
  arb_owner_t owner;

  logic in_idle;
  logic grant_dm;
  logic grant_if;
  logic starve_at_max;

  // Requests are only looked at in IDLE; during RESP the finished owner's
  // request is still high and must not start a second transaction.
  assign in_idle  = (state == ARB_IDLE);
  assign grant_dm = in_idle && bus.dm_req && !(bus.if_req && starve_at_max);
  assign grant_if = in_idle && bus.if_req && !grant_dm;

  arb_starve_counter #(
    .MAX (STARVE_MAX)
  ) u_starve (
    .clk    (clk),
    .rst    (rst),
    .inc    (grant_dm && bus.if_req),
    .clr    (grant_if || !bus.if_req),
    .at_max (starve_at_max)
  );

  // Stalls drop in the same cycle the valid pulse appears so the stage
  // advances exactly once per completed access.
  assign bus.stall_if  = !rst && bus.if_req && !bus.if_valid;
  assign bus.stall_mem = !rst && bus.dm_req && !bus.dm_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ARB_IDLE;
      owner         <= OWN_NONE;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.if_valid  <= 1'b0;
      bus.if_rdata  <= '0;
      bus.dm_valid  <= 1'b0;
      bus.dm_rdata  <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (grant_dm) begin
            owner         <= OWN_DM;
            bus.mem_we    <= bus.dm_we;
            bus.mem_addr  <= bus.dm_addr;
            bus.mem_wdata <= bus.dm_wdata;
            bus.mem_req   <= 1'b1;
            state         <= ARB_ISSUE;
          end else if (grant_if) begin
            owner         <= OWN_IF;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= bus.if_addr;
            bus.mem_wdata <= '0;
            bus.mem_req   <= 1'b1;
            state         <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          if (bus.mem_gnt) begin
            bus.mem_req <= 1'b0;
            state       <= ARB_WAIT;
          end
        end
        ARB_WAIT: begin
          if (bus.mem_rvalid) begin
            if (owner == OWN_IF) begin
              bus.if_rdata <= bus.mem_rdata;
              bus.if_valid <= 1'b1;
            end else begin
              // Stores complete through rvalid too, but carry no load data.
              if (!bus.mem_we) begin
                bus.dm_rdata <= bus.mem_rdata;
              end
              bus.dm_valid <= 1'b1;
            end
            state <= ARB_RESP;
          end
        end
        ARB_RESP: begin
          bus.if_valid <= 1'b0;
          bus.dm_valid <= 1'b0;
          owner        <= OWN_NONE;
          state        <= ARB_IDLE;
        end
        default: begin
          state <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed self-checking bench for mem_port_arbiter. The bench plays both the
//   pipeline (fetch/data requests) and the memory (gnt/rvalid), drives inputs on
//   the falling edge and checks outputs 1 time unit later.
module tb_mem_port_arbiter;

  logic clk;
  logic rst;

  int n_checks;
  int n_fail;

  logic [31:0] exp_dm_rdata;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(
    .STARVE_MAX (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // From an ISSUE-state falling edge: grant now, return read data one cycle
  // later. Returns on the falling edge of the RESP cycle.
  task automatic apply_stimulus(input logic [31:0] rdata);
    bus.mem_gnt = 1'b1;
    cycle();
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = rdata;
    cycle();
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'h0;
    #1;
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    exp_dm_rdata = 32'h0;

    rst            = 1'b1;
    bus.if_req     = 1'b1;
    bus.if_addr    = 32'h0;
    bus.dm_req     = 1'b1;
    bus.dm_we      = 1'b0;
    bus.dm_addr    = 32'h0;
    bus.dm_wdata   = 32'h0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'h0;

    // Reset: registered outputs zero, stalls forced low despite requests.
    repeat (2) cycle();
    #1;
    check_output("rst_stall_if", bus.stall_if, 32'h0);
    check_output("rst_stall_mem", bus.stall_mem, 32'h0);
    check_output("rst_mem_req", bus.mem_req, 32'h0);
    check_output("rst_mem_addr", bus.mem_addr, 32'h0);
    check_output("rst_if_valid", bus.if_valid, 32'h0);
    check_output("rst_dm_valid", bus.dm_valid, 32'h0);
    bus.if_req = 1'b0;
    bus.dm_req = 1'b0;
    rst        = 1'b0;
    cycle();

    // Fetch only: valid 3 cycles after request.
    $display("[TB] fetch only");
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h10;
    #1;
    check_output("f_stall_if_idle", bus.stall_if, 32'h1);
    check_output("f_mem_req_idle", bus.mem_req, 32'h0);
    cycle();
    #1;
    check_output("f_mem_req", bus.mem_req, 32'h1);
    check_output("f_mem_addr", bus.mem_addr, 32'h10);
    check_output("f_mem_we", bus.mem_we, 32'h0);
    bus.mem_gnt = 1'b1;
    cycle();
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h8C220004;
    #1;
    check_output("f_mem_req_wait", bus.mem_req, 32'h0);
    check_output("f_if_valid_wait", bus.if_valid, 32'h0);
    check_output("f_stall_if_wait", bus.stall_if, 32'h1);
    cycle();
    bus.mem_rvalid = 1'b0;
    #1;
    check_output("f_if_valid", bus.if_valid, 32'h1);
    check_output("f_if_rdata", bus.if_rdata, 32'h8C220004);
    check_output("f_stall_if_resp", bus.stall_if, 32'h0);
    bus.if_req = 1'b0;
    cycle();
    #1;
    check_output("f_if_valid_pulse", bus.if_valid, 32'h0);

    // Both request: data load first, fetch after.
    $display("[TB] both request");
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h20;
    bus.dm_req  = 1'b1;
    bus.dm_we   = 1'b0;
    bus.dm_addr = 32'h40;
    #1;
    check_output("b_stall_if", bus.stall_if, 32'h1);
    check_output("b_stall_mem", bus.stall_mem, 32'h1);
    cycle();
    #1;
    check_output("b_dm_addr", bus.mem_addr, 32'h40);
    check_output("b_dm_we", bus.mem_we, 32'h0);
    apply_stimulus(32'h11223344);
    exp_dm_rdata = 32'h11223344;
    check_output("b_dm_valid", bus.dm_valid, 32'h1);
    check_output("b_dm_rdata", bus.dm_rdata, exp_dm_rdata);
    check_output("b_stall_mem_resp", bus.stall_mem, 32'h0);
    check_output("b_stall_if_resp", bus.stall_if, 32'h1);
    bus.dm_req = 1'b0;
    cycle();
    #1;
    check_output("b_dm_valid_pulse", bus.dm_valid, 32'h0);
    check_output("b_stall_if_idle", bus.stall_if, 32'h1);
    cycle();
    #1;
    check_output("b_if_addr", bus.mem_addr, 32'h20);
    apply_stimulus(32'hA5A55A5A);
    check_output("b_if_valid", bus.if_valid, 32'h1);
    check_output("b_if_rdata", bus.if_rdata, 32'hA5A55A5A);
    bus.if_req = 1'b0;
    cycle();

    // Starvation: four back-to-back data grants, fifth arbitration to fetch.
    $display("[TB] starvation");
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h30;
    bus.dm_req  = 1'b1;
    bus.dm_we   = 1'b0;
    bus.dm_addr = 32'h50;
    cycle();
    #1;
    for (int i = 0; i < 4; i++) begin
      check_output($sformatf("s_dm_addr%0d", i), bus.mem_addr, 32'h50);
      apply_stimulus(32'h1000 + i);
      exp_dm_rdata = 32'h1000 + i;
      check_output($sformatf("s_dm_valid%0d", i), bus.dm_valid, 32'h1);
      check_output($sformatf("s_dm_rdata%0d", i), bus.dm_rdata, exp_dm_rdata);
      check_output($sformatf("s_if_valid%0d", i), bus.if_valid, 32'h0);
      cycle();
      cycle();
      #1;
    end
    check_output("s_if_wins_addr", bus.mem_addr, 32'h30);
    check_output("s_stall_mem", bus.stall_mem, 32'h1);
    apply_stimulus(32'hCAFE0001);
    check_output("s_if_valid", bus.if_valid, 32'h1);
    check_output("s_if_rdata", bus.if_rdata, 32'hCAFE0001);
    check_output("s_dm_valid_during_if", bus.dm_valid, 32'h0);
    bus.if_req = 1'b0;
    bus.dm_req = 1'b0;
    cycle();

    // Store: write enable and data forwarded, load data untouched.
    $display("[TB] store");
    bus.dm_req   = 1'b1;
    bus.dm_we    = 1'b1;
    bus.dm_addr  = 32'h80;
    bus.dm_wdata = 32'hDEADBEEF;
    cycle();
    #1;
    check_output("st_mem_we", bus.mem_we, 32'h1);
    check_output("st_mem_addr", bus.mem_addr, 32'h80);
    check_output("st_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
    apply_stimulus(32'hFFFFFFFF);
    check_output("st_dm_valid", bus.dm_valid, 32'h1);
    check_output("st_dm_rdata", bus.dm_rdata, exp_dm_rdata);
    bus.dm_req = 1'b0;
    bus.dm_we  = 1'b0;
    cycle();

    // Delayed grant: request and address held stable, stall held.
    $display("[TB] delayed grant");
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h44;
    cycle();
    #1;
    for (int i = 0; i < 3; i++) begin
      check_output($sformatf("g_mem_req%0d", i), bus.mem_req, 32'h1);
      check_output($sformatf("g_mem_addr%0d", i), bus.mem_addr, 32'h44);
      check_output($sformatf("g_stall_if%0d", i), bus.stall_if, 32'h1);
      cycle();
      #1;
    end
    check_output("g_mem_req_last", bus.mem_req, 32'h1);
    apply_stimulus(32'h0BADF00D);
    check_output("g_if_valid", bus.if_valid, 32'h1);
    check_output("g_if_rdata", bus.if_rdata, 32'h0BADF00D);
    bus.if_req = 1'b0;
    cycle();

    // Reset while waiting for rvalid: late rvalid ignored, next request served.
    $display("[TB] reset mid-transaction");
    bus.dm_req  = 1'b1;
    bus.dm_we   = 1'b0;
    bus.dm_addr = 32'h60;
    cycle();
    bus.mem_gnt = 1'b1;
    cycle();
    bus.mem_gnt = 1'b0;
    rst         = 1'b1;
    #1;
    check_output("r_stall_mem_forced", bus.stall_mem, 32'h0);
    cycle();
    #1;
    check_output("r_mem_addr", bus.mem_addr, 32'h0);
    check_output("r_dm_rdata", bus.dm_rdata, 32'h0);
    check_output("r_mem_req", bus.mem_req, 32'h0);
    rst            = 1'b0;
    bus.dm_req     = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h99;
    cycle();
    bus.mem_rvalid = 1'b0;
    #1;
    check_output("r_late_dm_valid", bus.dm_valid, 32'h0);
    check_output("r_late_if_valid", bus.if_valid, 32'h0);
    check_output("r_late_dm_rdata", bus.dm_rdata, 32'h0);
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h70;
    cycle();
    #1;
    check_output("r_next_mem_req", bus.mem_req, 32'h1);
    check_output("r_next_mem_addr", bus.mem_addr, 32'h70);
    apply_stimulus(32'h12345678);
    check_output("r_next_if_valid", bus.if_valid, 32'h1);
    check_output("r_next_if_rdata", bus.if_rdata, 32'h12345678);
    bus.if_req = 1'b0;
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
